spinnaker_fpgas_reg_bus_arbiter: RTL and testbench
==================================================

# spinnaker_fpgas_reg_bus_arbiter

Shares the single register-access bus in front of the SPI address decoder between two requesters: requester 0 is the SPI peek/poke engine and requester 1 is the on-FPGA boot-time configuration sequencer. The block serialises their transactions with a 2-way round-robin arbiter and issues exactly one single-cycle read or write strobe per transaction. It holds address and write data stable until the read value has been captured, then returns a one-cycle response to the requester that issued the transaction. It sits between the requesters and the address decoder; the decoder fans the strobes out to the B2B, peripheral and ring HSS blocks.

## Interface
- ADDR_BITS, 32, register address width, passed unchanged to the decoder
- VAL_BITS, 32, data word width
- READ_LATENCY, 1, cycles from read strobe to a valid BUS_READ_VALUE_IN; legal range 0..7

- CLK_IN  in  1  system clock; all logic is on the rising edge
- RESET_IN  in  1  reset; synchronous, active-high
- REQ_VLD_IN  in  2  bit r: requester r has a transaction pending
- REQ_RDY_OUT  out  2  bit r: transaction accepted this cycle
- REQ_WRITE_IN  in  2  bit r: 1 = write, 0 = read
- REQ_ADDR_IN  in  2*ADDR_BITS  requester r address at [r*ADDR_BITS+:ADDR_BITS]
- REQ_WDATA_IN  in  2*VAL_BITS  requester r write data at [r*VAL_BITS+:VAL_BITS]
- RSP_VLD_OUT  out  2  bit r: one-cycle completion pulse for requester r
- RSP_DATA_OUT  out  VAL_BITS  read data; shared by both requesters; qualified by RSP_VLD_OUT
- BUS_ADDR_OUT  out  ADDR_BITS  address to the decoder
- BUS_WDATA_OUT  out  VAL_BITS  write data to the devices
- BUS_READ_OUT  out  1  read strobe
- BUS_WRITE_OUT  out  1  write strobe
- BUS_READ_VALUE_IN  in  VAL_BITS  muxed read value from the decoder
- BUSY_OUT  out  1  high whenever the state is not IDLE

## Operation
- Valid/ready handshake on requests: a transfer occurs when REQ_VLD_IN[r] and REQ_RDY_OUT[r] are both high. A requester holds valid and payload until accepted. The response channel has no back-pressure.
- FSM states are IDLE, ISSUE, WAIT and RESP.
- **IDLE**
  - If any REQ_VLD_IN bit is set, grant one requester g and drive REQ_RDY_OUT[g]=1 combinationally. Ready is never asserted outside IDLE.
  - Register the granted address, write data and write flag, set last_grant=g, go to ISSUE.
- **Arbitration**
  - One requester valid: it wins.
  - Both valid: the requester other than last_grant wins.
  - last_grant resets to 1, so requester 0 wins the first tie.
- **ISSUE**
  - Assert BUS_WRITE_OUT or BUS_READ_OUT for exactly one cycle.
  - Write: go to RESP.
  - Read with READ_LATENCY=0: capture BUS_READ_VALUE_IN in this cycle and go to RESP.
  - Read with READ_LATENCY>0: load the wait counter with READ_LATENCY-1 and go to WAIT.
- **WAIT**
  - Strobes are low.
  - When the counter is 0, capture BUS_READ_VALUE_IN and go to RESP; otherwise decrement the counter.
- **RESP**
  - RSP_VLD_OUT[g]=1 for one cycle.
  - RSP_DATA_OUT = captured value for a read, 0 for a write.
  - Go to IDLE.
- BUS_ADDR_OUT and BUS_WDATA_OUT come from registers loaded only at acceptance. They stay stable through ISSUE, WAIT and RESP so the decoder keeps selecting the same device; between transactions they hold their last value.
- The block does not interpret the address; all address bits pass through to the decoder.

## Timing
- Reset values:
  - all outputs 0: REQ_RDY_OUT is 0 while RESET_IN is high; BUS_ADDR_OUT, BUS_WDATA_OUT and RSP_DATA_OUT are 0
  - state IDLE, last_grant=1, counter 0
- Write, accepted in cycle T:
  - strobe in T+1
  - RSP_VLD_OUT in T+2
  - next acceptance possible in T+3
- Read, accepted in cycle T:
  - strobe in T+1
  - BUS_READ_VALUE_IN sampled at the end of cycle T+1+READ_LATENCY
  - RSP_VLD_OUT in T+2+READ_LATENCY
  - next acceptance possible in T+3+READ_LATENCY
- Exactly one strobe per accepted transaction; BUS_READ_OUT and BUS_WRITE_OUT are never high together.
- Simultaneous requests with continuous valid on both sides: grants strictly alternate 0,1,0,1,...
- A new request arriving during a transaction waits, with ready low, until IDLE.
- Reset mid-transaction: the transaction is abandoned, no strobe or response is emitted after reset, and the requester re-requests.

## Structure
- Shared constants header holds:
  - state encodings: IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3
  - requester indices: REQ_SPI=0, REQ_LOCAL=1
- Sub-module spinnaker_fpgas_rr_arb2: 2-way round-robin grant.
  - Inputs: request[1:0] and last_grant.
  - Output: one-hot grant.
  - Purely combinational; last_grant is stored in the parent.

## Test plan
- **Single write, READ_LATENCY=1:** requester 0 writes address 0x8000_0010, data 0xDEAD_BEEF, accepted at T → BUS_WRITE_OUT high only at T+1 with that address and data; RSP_VLD_OUT=2'b01 at T+2.
- **Read, READ_LATENCY=3:** requester 1 reads 0xC000_0004; the model drives 0x1234_5678 only in cycle T+4 → RSP_VLD_OUT=2'b10 at T+5 with RSP_DATA_OUT=0x1234_5678; BUS_ADDR_OUT stable from T+1 to T+5.
- **READ_LATENCY=0 read:** value captured in the strobe cycle → response at T+2.
- **Contention:** both requesters hold valid for 6 transactions → grants 0,1,0,1,0,1; one strobe each; no dropped or duplicated responses.
- **Reset mid-read:** RESET_IN asserted in WAIT → next cycle all outputs 0, no RSP_VLD_OUT; after release, the first tie goes to requester 0.
- **Back-to-back writes from requester 0 only:** acceptances every 3 cycles; REQ_RDY_OUT never high outside IDLE.

Source files
------------

// File: rtl/spinnaker_fpgas_reg_bus_arbiter_pkg.sv
// Shared constants for the register-bus arbiter: FSM state encodings,
// requester indices and the width of the read-latency wait counter.
package spinnaker_fpgas_reg_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int REQ_SPI   = 0;
    localparam int REQ_LOCAL = 1;

    // Wide enough for READ_LATENCY-1 with READ_LATENCY up to 7.
    localparam int CNT_BITS = 3;

endpackage

// File: rtl/spinnaker_fpgas_rr_arb2.sv
// Two-way round-robin grant; the previous winner is held by the parent and
// only matters when both requesters are valid.
module spinnaker_fpgas_rr_arb2
    import spinnaker_fpgas_reg_bus_arbiter_pkg::*;
(
    input  logic [1:0] request,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = request;
        if (request == 2'b11) begin
            grant = '0;
            grant[last_grant ? REQ_SPI : REQ_LOCAL] = 1'b1;
        end
    end

endmodule

// File: rtl/spinnaker_fpgas_reg_bus_arbiter.sv
// Serialises register-bus transactions from the SPI engine and the boot
// sequencer, issuing one strobe per transaction and a one-cycle response.
module spinnaker_fpgas_reg_bus_arbiter
    import spinnaker_fpgas_reg_bus_arbiter_pkg::*;
#(
    parameter int ADDR_BITS    = 32,
    parameter int VAL_BITS     = 32,
    parameter int READ_LATENCY = 1
)
(
    input  logic                   CLK_IN,
    input  logic                   RESET_IN,
    input  logic [1:0]             REQ_VLD_IN,
    output logic [1:0]             REQ_RDY_OUT,
    input  logic [1:0]             REQ_WRITE_IN,
    input  logic [2*ADDR_BITS-1:0] REQ_ADDR_IN,
    input  logic [2*VAL_BITS-1:0]  REQ_WDATA_IN,
    output logic [1:0]             RSP_VLD_OUT,
    output logic [VAL_BITS-1:0]    RSP_DATA_OUT,
    output logic [ADDR_BITS-1:0]   BUS_ADDR_OUT,
    output logic [VAL_BITS-1:0]    BUS_WDATA_OUT,
    output logic                   BUS_READ_OUT,
    output logic                   BUS_WRITE_OUT,
    input  logic [VAL_BITS-1:0]    BUS_READ_VALUE_IN,
    output logic                   BUSY_OUT
);

    localparam logic [CNT_BITS-1:0] CNT_LOAD =
        CNT_BITS'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);

    state_t                state;
    state_t                next_state;
    logic                  last_grant;
    logic                  write_q;
    logic [ADDR_BITS-1:0]  addr_q;
    logic [VAL_BITS-1:0]   wdata_q;
    logic [VAL_BITS-1:0]   rdata_q;
    logic [CNT_BITS-1:0]   cnt;
    logic [1:0]            grant;
    logic                  grant_idx;
    logic                  accept;
    logic                  capture;
    logic                  cnt_load;

    spinnaker_fpgas_rr_arb2 u_arb (
        .request    (REQ_VLD_IN),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign grant_idx = grant[REQ_LOCAL];

    always_ff @(posedge CLK_IN) begin
        if (RESET_IN) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state    = state;
        accept        = 1'b0;
        capture       = 1'b0;
        cnt_load      = 1'b0;
        REQ_RDY_OUT   = '0;
        BUS_READ_OUT  = 1'b0;
        BUS_WRITE_OUT = 1'b0;
        RSP_VLD_OUT   = '0;
        case (state)
            IDLE: begin
                if ((|REQ_VLD_IN) && !RESET_IN) begin
                    REQ_RDY_OUT = grant;
                    accept      = 1'b1;
                    next_state  = ISSUE;
                end
            end
            ISSUE: begin
                BUS_WRITE_OUT = write_q;
                BUS_READ_OUT  = !write_q;
                if (write_q) begin
                    next_state = RESP;
                end else if (READ_LATENCY == 0) begin
                    capture    = 1'b1;
                    next_state = RESP;
                end else begin
                    cnt_load   = 1'b1;
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    capture    = 1'b1;
                    next_state = RESP;
                end
            end
            RESP: begin
                RSP_VLD_OUT = last_grant ? 2'b10 : 2'b01;
                next_state  = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Payload registers load only at acceptance so the decoder keeps its selection;
    // the read capture is cleared at acceptance so writes respond with zero.
    always_ff @(posedge CLK_IN) begin
        if (RESET_IN) begin
            last_grant <= 1'b1;
            write_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            cnt        <= '0;
        end else begin
            if (accept) begin
                last_grant <= grant_idx;
                write_q    <= REQ_WRITE_IN[grant_idx];
                addr_q     <= grant_idx ? REQ_ADDR_IN[ADDR_BITS +: ADDR_BITS]
                                        : REQ_ADDR_IN[0 +: ADDR_BITS];
                wdata_q    <= grant_idx ? REQ_WDATA_IN[VAL_BITS +: VAL_BITS]
                                        : REQ_WDATA_IN[0 +: VAL_BITS];
                rdata_q    <= '0;
            end
            if (cnt_load) begin
                cnt <= CNT_LOAD;
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - CNT_BITS'(1);
            end
            if (capture) begin
                rdata_q <= BUS_READ_VALUE_IN;
            end
        end
    end

    assign BUS_ADDR_OUT  = addr_q;
    assign BUS_WDATA_OUT = wdata_q;
    assign RSP_DATA_OUT  = rdata_q;
    assign BUSY_OUT      = (state != IDLE);

endmodule

// File: tb/tb_spinnaker_fpgas_reg_bus_arbiter.sv
// Directed self-checking bench: one arbiter with READ_LATENCY=3 for most
// scenarios and a second with READ_LATENCY=0 for the zero-latency read.
module tb_spinnaker_fpgas_reg_bus_arbiter;

    logic        clk_in = 1'b0;
    logic        reset_in;

    logic [1:0]  req_vld;
    logic [1:0]  req_rdy;
    logic [1:0]  req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  rsp_vld;
    logic [31:0] rsp_data;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_read;
    logic        bus_write;
    logic [31:0] bus_read_value;
    logic        busy;

    logic [1:0]  b_req_vld;
    logic [1:0]  b_req_rdy;
    logic [1:0]  b_rsp_vld;
    logic [31:0] b_rsp_data;
    logic [31:0] b_bus_addr;
    logic [31:0] b_bus_wdata;
    logic        b_bus_read;
    logic        b_bus_write;
    logic [31:0] b_bus_read_value;
    logic        b_busy;

    int check_count = 0;
    int pass_count  = 0;

    always #5 clk_in = ~clk_in;

    spinnaker_fpgas_reg_bus_arbiter #(
        .ADDR_BITS(32), .VAL_BITS(32), .READ_LATENCY(3)
    ) dut (
        .CLK_IN            (clk_in),
        .RESET_IN          (reset_in),
        .REQ_VLD_IN        (req_vld),
        .REQ_RDY_OUT       (req_rdy),
        .REQ_WRITE_IN      (req_write),
        .REQ_ADDR_IN       (req_addr),
        .REQ_WDATA_IN      (req_wdata),
        .RSP_VLD_OUT       (rsp_vld),
        .RSP_DATA_OUT      (rsp_data),
        .BUS_ADDR_OUT      (bus_addr),
        .BUS_WDATA_OUT     (bus_wdata),
        .BUS_READ_OUT      (bus_read),
        .BUS_WRITE_OUT     (bus_write),
        .BUS_READ_VALUE_IN (bus_read_value),
        .BUSY_OUT          (busy)
    );

    spinnaker_fpgas_reg_bus_arbiter #(
        .ADDR_BITS(32), .VAL_BITS(32), .READ_LATENCY(0)
    ) dut_lat0 (
        .CLK_IN            (clk_in),
        .RESET_IN          (reset_in),
        .REQ_VLD_IN        (b_req_vld),
        .REQ_RDY_OUT       (b_req_rdy),
        .REQ_WRITE_IN      (req_write),
        .REQ_ADDR_IN       (req_addr),
        .REQ_WDATA_IN      (req_wdata),
        .RSP_VLD_OUT       (b_rsp_vld),
        .RSP_DATA_OUT      (b_rsp_data),
        .BUS_ADDR_OUT      (b_bus_addr),
        .BUS_WDATA_OUT     (b_bus_wdata),
        .BUS_READ_OUT      (b_bus_read),
        .BUS_WRITE_OUT     (b_bus_write),
        .BUS_READ_VALUE_IN (b_bus_read_value),
        .BUSY_OUT          (b_busy)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        check_count++;
        if (observed === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] vld, input logic [1:0] write,
                                 input logic [31:0] addr0, input logic [31:0] addr1,
                                 input logic [31:0] wdata0, input logic [31:0] wdata1);
        req_vld   = vld;
        req_write = write;
        req_addr  = {addr1, addr0};
        req_wdata = {wdata1, wdata0};
        #1;
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        reset_in         = 1'b1;
        b_req_vld        = 2'b00;
        bus_read_value   = 32'hFFFF_FFFF;
        b_bus_read_value = 32'h0;
        applyStimulus(2'b11, 2'b11, 32'h1, 32'h2, 32'h3, 32'h4);
        repeat (3) step();

        // Reset state: ready gated by reset even with both requesters valid.
        checkOutput("rst_ready", req_rdy, 2'b00);
        checkOutput("rst_rsp_vld", rsp_vld, 2'b00);
        checkOutput("rst_strobes", {bus_read, bus_write}, 2'b00);
        checkOutput("rst_bus_addr", bus_addr, 32'h0);
        checkOutput("rst_bus_wdata", bus_wdata, 32'h0);
        checkOutput("rst_rsp_data", rsp_data, 32'h0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_lat0_busy", b_busy, 1'b0);

        // Single write from requester 0.
        reset_in = 1'b0;
        applyStimulus(2'b01, 2'b01, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 32'h0);
        checkOutput("wr_ready", req_rdy, 2'b01);
        step();
        applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        checkOutput("wr_strobe", {bus_read, bus_write}, 2'b01);
        checkOutput("wr_addr", bus_addr, 32'h8000_0010);
        checkOutput("wr_wdata", bus_wdata, 32'hDEAD_BEEF);
        checkOutput("wr_busy", busy, 1'b1);
        step();
        checkOutput("wr_strobe_off", {bus_read, bus_write}, 2'b00);
        checkOutput("wr_rsp_vld", rsp_vld, 2'b01);
        checkOutput("wr_rsp_data", rsp_data, 32'h0);
        step();
        checkOutput("wr_rsp_done", rsp_vld, 2'b00);
        checkOutput("wr_idle", busy, 1'b0);

        // Read from requester 1 with three cycles of latency.
        applyStimulus(2'b10, 2'b00, 32'h0, 32'hC000_0004, 32'h0, 32'h0);
        checkOutput("rd_ready", req_rdy, 2'b10);
        step();
        applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        checkOutput("rd_strobe", {bus_read, bus_write}, 2'b10);
        checkOutput("rd_addr_t1", bus_addr, 32'hC000_0004);
        step();
        checkOutput("rd_strobe_off", {bus_read, bus_write}, 2'b00);
        checkOutput("rd_addr_t2", bus_addr, 32'hC000_0004);
        step();
        checkOutput("rd_addr_t3", bus_addr, 32'hC000_0004);
        checkOutput("rd_no_early_rsp", rsp_vld, 2'b00);
        step();
        bus_read_value = 32'h1234_5678;
        #1;
        checkOutput("rd_addr_t4", bus_addr, 32'hC000_0004);
        checkOutput("rd_no_rsp_t4", rsp_vld, 2'b00);
        step();
        bus_read_value = 32'hFFFF_FFFF;
        #1;
        checkOutput("rd_rsp_vld", rsp_vld, 2'b10);
        checkOutput("rd_rsp_data", rsp_data, 32'h1234_5678);
        checkOutput("rd_addr_t5", bus_addr, 32'hC000_0004);
        step();
        checkOutput("rd_rsp_done", rsp_vld, 2'b00);
        checkOutput("rd_idle", busy, 1'b0);

        // Zero-latency read: captured in the strobe cycle.
        applyStimulus(2'b00, 2'b00, 32'h0000_0040, 32'h0, 32'h0, 32'h0);
        b_req_vld = 2'b01;
        #1;
        checkOutput("l0_ready", b_req_rdy, 2'b01);
        step();
        b_req_vld        = 2'b00;
        b_bus_read_value = 32'hA5A5_0F0F;
        #1;
        checkOutput("l0_strobe", {b_bus_read, b_bus_write}, 2'b10);
        checkOutput("l0_addr", b_bus_addr, 32'h0000_0040);
        step();
        b_bus_read_value = 32'h0;
        #1;
        checkOutput("l0_rsp_vld", b_rsp_vld, 2'b01);
        checkOutput("l0_rsp_data", b_rsp_data, 32'hA5A5_0F0F);
        step();
        checkOutput("l0_rsp_done", b_rsp_vld, 2'b00);
        checkOutput("l0_idle", b_busy, 1'b0);

        // Contention: both valid for six write transactions, grants alternate.
        applyStimulus(2'b11, 2'b11, 32'hA000_0000, 32'hB000_0000, 32'h0A0A, 32'h0B0B);
        for (int i = 0; i < 18; i++) begin
            logic [1:0] exp_g;
            exp_g = (((i / 3) % 2) == 0) ? 2'b01 : 2'b10;
            checkOutput("ctn_ready", req_rdy, (i % 3 == 0) ? exp_g : 2'b00);
            checkOutput("ctn_strobe", {bus_read, bus_write}, (i % 3 == 1) ? 2'b01 : 2'b00);
            if (i % 3 == 1) begin
                checkOutput("ctn_addr", bus_addr, exp_g[1] ? 32'hB000_0000 : 32'hA000_0000);
                checkOutput("ctn_wdata", bus_wdata, exp_g[1] ? 32'h0B0B : 32'h0A0A);
            end
            checkOutput("ctn_rsp", rsp_vld, (i % 3 == 2) ? exp_g : 2'b00);
            step();
        end
        applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        checkOutput("ctn_idle", busy, 1'b0);

        // Reset during WAIT of a read from requester 0.
        applyStimulus(2'b01, 2'b00, 32'h1111_0000, 32'h0, 32'h0, 32'h0);
        checkOutput("mr_ready", req_rdy, 2'b01);
        step();
        applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        checkOutput("mr_strobe", {bus_read, bus_write}, 2'b10);
        step();
        checkOutput("mr_wait_busy", busy, 1'b1);
        reset_in = 1'b1;
        step();
        applyStimulus(2'b11, 2'b11, 32'h2222_0000, 32'h3333_0000, 32'h1, 32'h2);
        checkOutput("mr_ready_rst", req_rdy, 2'b00);
        checkOutput("mr_rsp_vld", rsp_vld, 2'b00);
        checkOutput("mr_strobes", {bus_read, bus_write}, 2'b00);
        checkOutput("mr_busy", busy, 1'b0);
        checkOutput("mr_bus_addr", bus_addr, 32'h0);
        checkOutput("mr_bus_wdata", bus_wdata, 32'h0);
        checkOutput("mr_rsp_data", rsp_data, 32'h0);
        step();
        checkOutput("mr_rsp_vld2", rsp_vld, 2'b00);
        reset_in = 1'b0;
        #1;
        checkOutput("mr_tie_after_rst", req_rdy, 2'b01);
        step();
        applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        checkOutput("mr_rsp_vld3", rsp_vld, 2'b00);
        checkOutput("mr_wr_strobe", {bus_read, bus_write}, 2'b01);
        checkOutput("mr_wr_addr", bus_addr, 32'h2222_0000);
        step();
        checkOutput("mr_wr_rsp", rsp_vld, 2'b01);
        step();

        // Back-to-back writes from requester 0 only.
        applyStimulus(2'b01, 2'b01, 32'h8000_0100, 32'h0, 32'h5555_AAAA, 32'h0);
        for (int i = 0; i < 9; i++) begin
            checkOutput("b2b_ready", req_rdy, (i % 3 == 0) ? 2'b01 : 2'b00);
            checkOutput("b2b_busy", busy, (i % 3 == 0) ? 1'b0 : 1'b1);
            checkOutput("b2b_strobe", {bus_read, bus_write}, (i % 3 == 1) ? 2'b01 : 2'b00);
            checkOutput("b2b_rsp", rsp_vld, (i % 3 == 2) ? 2'b01 : 2'b00);
            step();
        end
        applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        checkOutput("b2b_idle", busy, 1'b0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
